// File: rtl/memory_tank_ctrl.sv
// Recirculating mercury-tank store with a word-addressed access controller.
// WORDS short words circulate bit-serially, LSB first, one digit per r2_clk.
// An access waits for its word to reach the tank head, then moves it serially.
// Digit MINOR_BITS-1 of each word is the gap digit. In an even word it may hold
// the sandwich digit of a long word, so it is kept as it circulates. In an odd
// word it never holds data and always circulates as 0.
// WORDS is expected to be even and at least 2.
module memory_tank_ctrl #(
    parameter int unsigned MINOR_BITS = 18,
    parameter int unsigned WORDS      = 32
) (
    input  logic                          r2_clk,
    input  logic                          r2_rst,
    input  logic [$clog2(WORDS)-1:0]      r2_addr,
    input  logic                          r2_long,
    input  logic                          r2_rd_req,
    input  logic                          r2_wr_req,
    input  logic                          r2_clr_req,
    input  logic                          r2_mib,
    output logic                          r2_mob,
    output logic                          r2_mob_valid,
    output logic                          r2_busy,
    output logic                          r2_done,
    output logic                          monitor,
    output logic [$clog2(WORDS)-1:0]      r2_word_pos,
    output logic [$clog2(MINOR_BITS)-1:0] r2_digit_pos
);

    localparam int unsigned DEPTH = WORDS * MINOR_BITS;
    localparam int unsigned AW    = $clog2(WORDS);
    localparam int unsigned DW    = $clog2(MINOR_BITS);
    localparam int unsigned CW    = $clog2(2 * MINOR_BITS);

    localparam logic [DW-1:0] DIGIT_LAST = DW'(MINOR_BITS - 1);
    localparam logic [AW-1:0] WORD_LAST  = AW'(WORDS - 1);
    localparam logic [CW-1:0] SHORT_LAST = CW'(MINOR_BITS - 1);
    localparam logic [CW-1:0] LONG_LAST  = CW'(2 * MINOR_BITS - 1);

    typedef enum logic [1:0] {StIdle, StWait, StXfer, StDone} state_e;
    typedef enum logic [1:0] {OpRd, OpWr, OpClr} op_e;

    // Tank: bit 0 is the head, bit DEPTH-1 is the tail slot refilled each cycle.
    logic [DEPTH-1:0] tank_q;
    logic             tail;
    logic             head;

    logic [DW-1:0]    digit_q;
    logic [AW-1:0]    word_q;
    logic [AW-1:0]    word_nxt;
    logic             digit_wrap;

    state_e           state_q, state_d;
    op_e              op_q, op_d;
    logic [AW-1:0]    addr_q, addr_d;
    logic             long_q, long_d;
    logic [CW-1:0]    cnt_q, cnt_d;

    logic             req_any;
    logic [AW-1:0]    req_addr;
    logic             start_from_idle;
    logic             start_from_wait;
    logic [CW-1:0]    xfer_last;
    logic             in_xfer;
    logic             is_gap;
    logic             sandwich;

    assign head       = tank_q[0];
    assign digit_wrap = (digit_q == DIGIT_LAST);
    assign word_nxt   = (word_q == WORD_LAST) ? '0 : word_q + AW'(1);

    // A long access always starts on the even word of its pair.
    assign req_any  = r2_rd_req | r2_wr_req | r2_clr_req;
    assign req_addr = r2_addr & ~AW'(r2_long);

    // The transfer starts on the cycle whose head is digit 0 of the target word,
    // so the decision is made one cycle earlier from the next head position.
    assign start_from_idle = digit_wrap && (word_nxt == req_addr);
    assign start_from_wait = digit_wrap && (word_nxt == addr_q);

    assign xfer_last = long_q ? LONG_LAST : SHORT_LAST;
    assign in_xfer   = (state_q == StXfer);
    assign is_gap    = digit_wrap;
    // Gap digit of the even word carries data only during a long access.
    assign sandwich  = long_q && !word_q[0];

    // Head position counters: digit every cycle, word on digit wrap.
    always_ff @(posedge r2_clk or posedge r2_rst) begin
        if (r2_rst) begin
            digit_q <= '0;
            word_q  <= '0;
        end else begin
            if (digit_wrap) begin
                digit_q <= '0;
                word_q  <= word_nxt;
            end else begin
                digit_q <= digit_q + DW'(1);
            end
        end
    end

    // Tail digit selection: recirculate, take r2_mib, or zero.
    always_comb begin
        tail = head;
        if (is_gap && word_q[0]) begin
            tail = 1'b0;
        end
        if (in_xfer) begin
            case (op_q)
                OpWr:    tail = (is_gap && !sandwich) ? 1'b0 : r2_mib;
                OpClr:   tail = 1'b0;
                default: tail = head;
            endcase
        end
    end

    // Tank shift: head leaves, tail digit enters.
    always_ff @(posedge r2_clk or posedge r2_rst) begin
        if (r2_rst) begin
            tank_q <= '0;
        end else begin
            tank_q <= {tail, tank_q[DEPTH-1:1]};
        end
    end

    // Controller state and latched access parameters.
    always_ff @(posedge r2_clk or posedge r2_rst) begin
        if (r2_rst) begin
            state_q <= StIdle;
            op_q    <= OpRd;
            addr_q  <= '0;
            long_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            addr_q  <= addr_d;
            long_q  <= long_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state logic: requests are only taken in idle, clear > write > read.
    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        addr_d  = addr_q;
        long_d  = long_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            StIdle: begin
                if (req_any) begin
                    op_d    = r2_clr_req ? OpClr : (r2_wr_req ? OpWr : OpRd);
                    addr_d  = req_addr;
                    long_d  = r2_long;
                    cnt_d   = '0;
                    state_d = start_from_idle ? StXfer : StWait;
                end
            end
            StWait: begin
                cnt_d = '0;
                if (start_from_wait) begin
                    state_d = StXfer;
                end
            end
            StXfer: begin
                if (cnt_q == xfer_last) begin
                    state_d = StDone;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            StDone: begin
                state_d = StIdle;
            end
        endcase
    end

    // Outputs: status from state, read data gated so gap digits never appear.
    always_comb begin
        r2_busy      = (state_q != StIdle);
        r2_done      = (state_q == StDone);
        r2_mob_valid = in_xfer && (op_q == OpRd);
        r2_mob       = r2_mob_valid && head && !(is_gap && !sandwich);
        monitor      = head;
        r2_word_pos  = word_q;
        r2_digit_pos = digit_q;
    end

endmodule
